// File: rtl/axis_s_interface.sv
// rtl/axis_s_interface.sv - read side of the AXIS SERDES link: byte FIFO -> word assembler -> AXIS word buffer
module axis_s_interface #(
  parameter int LOGIC_SIZE = 32,
  parameter int OUT_DEPTH  = 2
) (
  input  logic                                s_axis_aclk,
  input  logic                                s_axis_reset_n,
  output logic [LOGIC_SIZE-1:0]               s_axis_tdata,
  output logic                                s_axis_valid,
  input  logic                                s_axis_ready,
  input  logic [7:0]                          i_from_fifo,
  input  logic                                r_empty,
  output logic                                r_req,
  output logic [$clog2(LOGIC_SIZE/8)-1:0]     o_bytes_held
);

  localparam int FS = LOGIC_SIZE / 8;
  localparam int IW = $clog2(FS);
  localparam int PW = $clog2(OUT_DEPTH);
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam logic [IW-1:0] LAST  = IW'(FS - 1);
  localparam logic [CW-1:0] DEPTH = CW'(OUT_DEPTH);

  logic [IW-1:0]         req_idx, asm_idx;
  logic                  rd_pend;
  logic [LOGIC_SIZE-1:0] asm_word;
  logic [LOGIC_SIZE-1:0] mem [OUT_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr, rd_ptr_n;
  logic [CW-1:0]         count, count_n, slots;
  logic                  reserve, push, pop;
  logic [LOGIC_SIZE-1:0] push_word, head_n;

  // A final byte is only requested once a buffer slot is reserved for its word.
  assign r_req   = s_axis_reset_n && !r_empty && (req_idx != LAST || slots < DEPTH);
  assign reserve = r_req && (req_idx == LAST);
  assign push    = rd_pend && (asm_idx == LAST);
  assign pop     = s_axis_valid && s_axis_ready;
  assign push_word    = {i_from_fifo, asm_word[LOGIC_SIZE-9:0]};
  assign o_bytes_held = asm_idx;

  always_comb begin
    rd_ptr_n = rd_ptr + PW'(pop);
    count_n  = count + CW'(push) - CW'(pop);
    head_n   = mem[rd_ptr_n];
    // A word pushed straight into the next head slot bypasses the array.
    if (push && (wr_ptr == rd_ptr_n))
      head_n = push_word;
  end

  always_ff @(posedge s_axis_aclk) begin
    if (push)
      mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_reset_n) begin
    if (!s_axis_reset_n) begin
      req_idx      <= '0;
      asm_idx      <= '0;
      rd_pend      <= 1'b0;
      asm_word     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      slots        <= '0;
      s_axis_tdata <= '0;
      s_axis_valid <= 1'b0;
    end else begin
      rd_pend <= r_req;
      if (r_req)
        req_idx <= (req_idx == LAST) ? '0 : req_idx + 1'b1;
      slots <= slots + CW'(reserve) - CW'(pop);

      if (rd_pend) begin
        if (asm_idx == LAST) begin
          asm_idx  <= '0;
          asm_word <= '0;
        end else begin
          asm_idx <= asm_idx + 1'b1;
          asm_word[asm_idx*8 +: 8] <= i_from_fifo;
        end
      end

      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_n;
      count  <= count_n;

      s_axis_valid <= (count_n != '0);
      // Empty buffer keeps the last delivered word on tdata.
      if (count_n != '0)
        s_axis_tdata <= head_n;
    end
  end

endmodule

// File: tb/tb_axis_s_interface.sv
// tb/tb_axis_s_interface.sv - self-checking bench for axis_s_interface
module tb_axis_s_interface;
  localparam int LS = 32;
  localparam int OD = 2;
  localparam int FS = LS / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [LS-1:0] tdata;
  logic          valid;
  logic          ready = 1'b0;
  logic [7:0]    din = 8'h00;
  logic          r_empty = 1'b1;
  logic          r_req;
  logic [1:0]    held;

  axis_s_interface #(.LOGIC_SIZE(LS), .OUT_DEPTH(OD)) dut (
    .s_axis_aclk(clk), .s_axis_reset_n(rst_n), .s_axis_tdata(tdata), .s_axis_valid(valid),
    .s_axis_ready(ready), .i_from_fifo(din), .r_empty(r_empty), .r_req(r_req), .o_bytes_held(held)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] w;
  } vec_t;

  int n_cmp = 0, n_bad = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] sent_q[$];
  int requested, captured, popped;
  bit pend, prev_hold, starve;
  logic [7:0] pend_byte;
  logic [LS-1:0] prev_data, last_word;
  int ready_mode;
  bit s_req, s_valid;
  logic [1:0] s_held;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LS-1:0] exp_word(int n);
    return {sent_q[4*n+3], sent_q[4*n+2], sent_q[4*n+1], sent_q[4*n]};
  endfunction

  task automatic model_reset();
    fifo_q.delete();
    sent_q.delete();
    requested = 0; captured = 0; popped = 0;
    pend = 0; prev_hold = 0; last_word = '0;
  endtask

  // One clock cycle: drive inputs, sample and check mid-cycle, advance the model.
  task automatic step();
    r_empty = (fifo_q.size() == 0) || (starve && ($urandom_range(0, 1) == 1));
    ready   = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(ready_mode);
    @(negedge clk);
    s_req = r_req; s_valid = valid; s_held = held;
    chk("bytes_held", held, 64'(captured % FS));
    chk("valid", valid, 64'((captured / FS - popped) > 0));
    chk("r_req", r_req, 64'(rst_n && !r_empty &&
        ((requested % FS != FS - 1) || (requested / FS - popped < OD))));
    if (prev_hold) begin
      chk("stable_valid", valid, 1);
      chk("stable_data", tdata, prev_data);
    end
    if (!valid) chk("idle_data", tdata, last_word);
    if (valid && ready) begin
      if (4 * popped + 3 < sent_q.size()) chk("word", tdata, exp_word(popped));
      else chk("word_extra", tdata, ~tdata);
      popped++;
      last_word = tdata;
    end
    prev_hold = valid && !ready;
    prev_data = tdata;
    if (pend) captured++;
    pend = r_req;
    if (r_req) begin
      pend_byte = (fifo_q.size() > 0) ? fifo_q.pop_front() : 8'h00;
      sent_q.push_back(pend_byte);
      requested++;
    end
    @(posedge clk);
    #1;
    din = pend ? pend_byte : 8'($urandom);
  endtask

  task automatic drain(string name, int maxc);
    int c = 0;
    while (!(fifo_q.size() == 0 && !pend && captured == requested && popped * FS == captured)) begin
      if (c >= maxc) begin
        chk({name, "_timeout"}, c, maxc + 1);
        return;
      end
      step();
      c++;
    end
    repeat (2) step();
  endtask

  vec_t tbl[4];
  int rc, vc, vlen, p0;

  initial begin
    tbl[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 32'h44332211};
    tbl[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000};
    tbl[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFFFFFF};
    tbl[3] = '{8'h01, 8'h00, 8'h00, 8'h80, 32'h80000001};
    model_reset();
    starve = 0;
    ready_mode = 1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tdata", tdata, 0);
    chk("rst_valid", valid, 0);
    chk("rst_r_req", r_req, 0);
    chk("rst_held", held, 0);
    rst_n = 1'b1;
    step();

    // T2: single word latency and pulse width
    fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    rc = -1; vc = -1; vlen = 0;
    for (int c = 0; c < 14; c++) begin
      step();
      if (s_req && rc < 0) rc = c;
      if (s_valid && vc < 0) vc = c;
      if (s_valid) vlen++;
    end
    chk("t2_latency", vc - rc, 5);
    chk("t2_valid_len", vlen, 1);
    chk("t2_word", last_word, 32'h44332211);

    // Table of single words
    foreach (tbl[i]) begin
      fifo_q = '{tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].b3};
      drain("vec", 30);
      chk("vec_word", last_word, tbl[i].w);
    end

    // T1: asynchronous reset mid-word discards the partial word
    fifo_q = '{8'hAA, 8'hBB};
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("t1_tdata", tdata, 0);
    chk("t1_valid", valid, 0);
    chk("t1_r_req", r_req, 0);
    chk("t1_held", held, 0);
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    fifo_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    drain("t1", 30);
    chk("t1_fresh_word", last_word, 32'h04030201);
    chk("t1_word_count", popped, 1);

    // T3: 64-byte continuous stream
    p0 = popped;
    for (int i = 0; i < 64; i++) fifo_q.push_back(8'($urandom));
    drain("t3", 120);
    chk("t3_words", popped - p0, 16);

    // T4: backpressure fills the buffer, then drains in order
    ready_mode = 0;
    p0 = popped;
    for (int i = 0; i < 16; i++) fifo_q.push_back(8'($urandom));
    repeat (24) step();
    chk("t4_r_req_blocked", s_req, 0);
    chk("t4_held", s_held, 3);
    chk("t4_valid", s_valid, 1);
    chk("t4_no_pop", popped - p0, 0);
    ready_mode = 1;
    drain("t4", 60);
    chk("t4_words", popped - p0, 4);

    // T5: random starvation and random ready
    starve = 1;
    ready_mode = 2;
    p0 = popped;
    for (int i = 0; i < 120; i++) fifo_q.push_back(8'($urandom));
    drain("t5", 2000);
    chk("t5_words", popped - p0, 30);

    // T6: random ready with a full buffer, pushes and pops colliding
    starve = 0;
    p0 = popped;
    for (int i = 0; i < 80; i++) fifo_q.push_back(8'($urandom));
    drain("t6", 2000);
    chk("t6_words", popped - p0, 20);
    chk("total_words", popped * FS, sent_q.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
